cacheline_mem_scheduler: RTL and testbench

- Stateful scheduler between the split I-cache/D-cache miss ports and the single cacheline-adapter port.
- Latches one request at grant time and holds the address, write data and command stable until pmem_resp.
- Routes the response to the owning cache only, and alternates priority on simultaneous requests so neither cache starves.
- Includes a sticky hang detector on the physical-memory port.

---
 rtl/cacheline_mem_scheduler_if.sv | 38 +++
 rtl/cacheline_mem_scheduler.sv | 104 ++++++++++
 tb/tb_cacheline_mem_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_mem_scheduler_if.sv
// Signal bundle between the split I/D miss ports, the scheduler and the cacheline adapter.
// slave: the scheduler's view. master: the caches-plus-adapter environment driving it.
interface cacheline_mem_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  instr_read;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  data_read;
  logic                  data_write;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [LINE_WIDTH-1:0] data_mem_wdata;
  logic                  instr_mem_resp;
  logic [LINE_WIDTH-1:0] instr_cacheline;
  logic                  data_mem_resp;
  logic [LINE_WIDTH-1:0] data_cacheline;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_timeout;

  modport slave (
    input  instr_read, instr_addr, data_read, data_write, data_addr, data_mem_wdata,
    input  pmem_rdata, pmem_resp,
    output instr_mem_resp, instr_cacheline, data_mem_resp, data_cacheline,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_timeout
  );

  modport master (
    output instr_read, instr_addr, data_read, data_write, data_addr, data_mem_wdata,
    output pmem_rdata, pmem_resp,
    input  instr_mem_resp, instr_cacheline, data_mem_resp, data_cacheline,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_timeout
  );
endinterface

// File: rtl/cacheline_mem_scheduler.sv
// Arbitrates I-cache and D-cache line misses onto one cacheline adapter, holding the
// granted command stable until pmem_resp, with round-robin ties and a sticky hang flag.
module cacheline_mem_scheduler #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cacheline_mem_scheduler_if.slave bus_if
);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0]  TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  // IDLE arbitrate | I_RD/D_RD/D_WR command held on adapter | DONE one-cycle bubble
  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_e;

  state_e                state_q, state_d;
  logic                  last_data_q, last_data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  d_req, grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_data_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;

    // On a tie the I-cache wins only if the D-cache was served last.
    d_req   = bus_if.data_read | bus_if.data_write;
    grant_i = bus_if.instr_read & (~d_req | last_data_q);
    grant_d = d_req & ~grant_i;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d     = I_RD;
          last_data_d = 1'b0;
          addr_d      = bus_if.instr_addr & LINE_MASK;
          cnt_d       = '0;
        end else if (grant_d) begin
          state_d     = bus_if.data_write ? D_WR : D_RD;
          last_data_d = 1'b1;
          addr_d      = bus_if.data_addr & LINE_MASK;
          cnt_d       = '0;
          if (bus_if.data_write) begin
            wdata_d = bus_if.data_mem_wdata;
          end
        end
      end
      I_RD, D_RD, D_WR: begin
        if (bus_if.pmem_resp) begin
          state_d = DONE;
        end else if (cnt_q != TIMEOUT_VAL) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cnt_d == TIMEOUT_VAL) begin
      timeout_d = 1'b1;
    end
  end

  assign bus_if.pmem_read       = (state_q == I_RD) || (state_q == D_RD);
  assign bus_if.pmem_write      = (state_q == D_WR);
  assign bus_if.pmem_address    = addr_q;
  assign bus_if.pmem_wdata      = (state_q == D_WR) ? wdata_q : '0;
  assign bus_if.pmem_timeout    = timeout_q;
  // A reset cycle abandons the transaction, so its completion must not leak out.
  assign bus_if.instr_mem_resp  = rst_n && (state_q == I_RD) && bus_if.pmem_resp;
  assign bus_if.data_mem_resp   = rst_n && ((state_q == D_RD) || (state_q == D_WR))
                                  && bus_if.pmem_resp;
  assign bus_if.instr_cacheline = (state_q == I_RD) ? bus_if.pmem_rdata : '0;
  assign bus_if.data_cacheline  = (state_q == D_RD) ? bus_if.pmem_rdata : '0;
endmodule

// File: tb/tb_cacheline_mem_scheduler.sv
// Scoreboard bench: stimulus pushes expected grants, a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_cacheline_mem_scheduler;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 16;
  localparam int LB = LW / 8;
  localparam int K_IRD = 0;
  localparam int K_DRD = 1;
  localparam int K_DWR = 2;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    bit            follows;
    int            start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_pushed = 0;
  int   n_served = 0;
  int   n_abandoned = 0;
  bit   last_data = 1'b1;

  exp_t exp_q[$];
  exp_t cur;
  bit   in_txn = 1'b0;
  int   busy_cnt = 0;
  bit   exp_to = 1'b0;
  bit   post_rst = 1'b0;
  int   last_resp_cyc = -100;

  bit            adp_hold = 1'b0;
  bit            adp_pat_en = 1'b0;
  logic [LW-1:0] adp_pat = '0;
  int            adp_lat = -1;
  int            stray_req = 0;
  int            stray_done = 0;
  bit            adp_active = 1'b0;
  int            adp_wait = 0;

  cacheline_mem_scheduler_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  cacheline_mem_scheduler #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_if(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] a);
    return a - (a % AW'(LB));
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input exp_t e);
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Adapter model: answers each command after a latency, or on request answers while idle.
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.pmem_rdata = adp_pat_en ? adp_pat : rand_line();
      bus.pmem_resp  = 1'b0;
      if (stray_req != stray_done) begin
        bus.pmem_resp = 1'b1;
        stray_done    = stray_req;
      end else if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
        if (!adp_active) begin
          adp_active = 1'b1;
          adp_wait   = (adp_lat >= 0) ? adp_lat : $urandom_range(0, 6);
        end
        if (!adp_hold) begin
          if (adp_wait == 0) begin
            bus.pmem_resp = 1'b1;
            adp_active    = 1'b0;
          end else begin
            adp_wait--;
          end
        end
      end else begin
        adp_active = 1'b0;
      end
    end
  end

  // Monitor: compares every cycle against the expected-grant queue and timeout model.
  always @(negedge clk) begin
    logic cmd;
    int   exp_rise;
    cmd = bus.pmem_read | bus.pmem_write;
    if (post_rst) begin
      check("reset_ctrl", LW'({bus.pmem_read, bus.pmem_write, bus.instr_mem_resp,
                               bus.data_mem_resp, bus.pmem_timeout}), '0);
      check("reset_addr", LW'(bus.pmem_address), '0);
      check("reset_wdata", bus.pmem_wdata, '0);
      check("reset_lines", bus.instr_cacheline | bus.data_cacheline, '0);
      post_rst = 1'b0;
    end
    if (!rst_n) begin
      check("no_resp_in_reset", LW'({bus.instr_mem_resp, bus.data_mem_resp}), '0);
      n_abandoned += exp_q.size() + (in_txn ? 1 : 0);
      exp_q.delete();
      in_txn   = 1'b0;
      busy_cnt = 0;
      exp_to   = 1'b0;
      post_rst = 1'b1;
    end else begin
      check("timeout_flag", LW'(bus.pmem_timeout), LW'(exp_to));
      check("cmd_exclusive", LW'(bus.pmem_read & bus.pmem_write), '0);
      if (cmd && !in_txn) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", LW'(cmd), '0);
        end else begin
          cur      = exp_q.pop_front();
          in_txn   = 1'b1;
          busy_cnt = 0;
          exp_rise = cur.follows ? last_resp_cyc + 3 : cur.start_cyc + 1;
          check("grant_cycle", LW'(cyc), LW'(exp_rise));
        end
      end
      if (cmd && in_txn) begin
        check("cmd_kind", LW'({bus.pmem_read, bus.pmem_write}), (cur.kind == K_DWR) ? LW'(1) : LW'(2));
        check("pmem_address", LW'(bus.pmem_address), LW'(cur.addr));
        check("pmem_wdata", bus.pmem_wdata, (cur.kind == K_DWR) ? cur.wdata : '0);
        check("instr_line", bus.instr_cacheline, (cur.kind == K_IRD) ? bus.pmem_rdata : '0);
        check("data_line", bus.data_cacheline, (cur.kind == K_DRD) ? bus.pmem_rdata : '0);
        if (bus.pmem_resp) begin
          check("instr_resp", LW'(bus.instr_mem_resp), LW'(cur.kind == K_IRD));
          check("data_resp", LW'(bus.data_mem_resp), LW'(cur.kind != K_IRD));
          in_txn        = 1'b0;
          last_resp_cyc = cyc;
          n_served++;
        end else begin
          check("no_resp_busy", LW'({bus.instr_mem_resp, bus.data_mem_resp}), '0);
          if (busy_cnt < TO) busy_cnt++;
          if (busy_cnt >= TO) exp_to = 1'b1;
        end
      end else begin
        if (!cmd && in_txn) begin
          check("cmd_dropped", LW'(cmd), LW'(1));
          in_txn = 1'b0;
        end
        check("idle_no_resp", LW'({bus.instr_mem_resp, bus.data_mem_resp}), '0);
        check("idle_wdata", bus.pmem_wdata, '0);
        check("idle_lines", bus.instr_cacheline | bus.data_cacheline, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Caches hold their request until their own response, then drop it.
  task automatic serve(input bit i_p0, input bit d_p0, input bit d_first, input bit perturb);
    bit i_p, d_p, drop_i, drop_d, pert, owner_d;
    int budget;
    i_p = i_p0;
    d_p = d_p0;
    budget = 300;
    while ((i_p || d_p) && budget > 0) begin
      @(negedge clk);
      budget--;
      drop_i  = 1'b0;
      drop_d  = 1'b0;
      owner_d = (i_p && d_p) ? d_first : d_p;
      pert    = perturb && (bus.pmem_read || bus.pmem_write) &&
                !bus.instr_mem_resp && !bus.data_mem_resp;
      if (bus.instr_mem_resp && i_p) begin i_p = 1'b0; drop_i = 1'b1; end
      if (bus.data_mem_resp && d_p) begin d_p = 1'b0; drop_d = 1'b1; end
      tick();
      if (drop_i) bus.instr_read = 1'b0;
      if (drop_d) begin bus.data_read = 1'b0; bus.data_write = 1'b0; end
      if (pert) begin
        if (owner_d) begin
          bus.data_addr      = ($urandom_range(0, 1) == 0) ? AW'(0) : AW'($urandom);
          bus.data_mem_wdata = rand_line();
        end else begin
          bus.instr_addr = $urandom;
        end
      end
    end
    if (i_p || d_p) begin
      check("serve_budget", LW'({i_p, d_p}), '0);
      bus.instr_read = 1'b0;
      bus.data_read  = 1'b0;
      bus.data_write = 1'b0;
    end
  endtask

  task automatic round(input bit do_i, input bit do_d, input bit d_wr, input bit d_rd_too,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da,
                       input logic [LW-1:0] wd, input bit perturb);
    exp_t e_i, e_d;
    bit   i_first;
    e_i.kind = K_IRD; e_i.addr = line_addr(ia); e_i.wdata = '0;
    e_i.follows = 1'b0; e_i.start_cyc = cyc;
    e_d.kind = d_wr ? K_DWR : K_DRD; e_d.addr = line_addr(da); e_d.wdata = wd;
    e_d.follows = 1'b0; e_d.start_cyc = cyc;
    i_first = do_i && (!do_d || last_data);
    if (do_i && do_d) begin
      if (i_first) begin e_d.follows = 1'b1; push(e_i); push(e_d); end
      else begin e_i.follows = 1'b1; push(e_d); push(e_i); end
    end else if (do_i) begin
      push(e_i);
    end else if (do_d) begin
      push(e_d);
    end
    if (do_i && !do_d) last_data = 1'b0;
    else if (do_d && !do_i) last_data = 1'b1;
    bus.instr_read     = do_i;
    bus.instr_addr     = ia;
    bus.data_read      = do_d && (!d_wr || d_rd_too);
    bus.data_write     = do_d && d_wr;
    bus.data_addr      = da;
    bus.data_mem_wdata = wd;
    serve(do_i, do_d, !i_first, perturb);
    repeat (1 + $urandom_range(0, 2)) tick();
  endtask

  initial begin
    exp_t e;
    bus.instr_read = 1'b0; bus.instr_addr = '0;
    bus.data_read = 1'b0; bus.data_write = 1'b0; bus.data_addr = '0; bus.data_mem_wdata = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Ties right after reset: the I-cache must win the first one.
    round(1, 1, 0, 0, 32'h0000_2468, 32'h0000_9A30, rand_line(), 0);
    round(1, 1, 1, 1, 32'h0000_4000, 32'h0000_7FFF, rand_line(), 1);

    adp_lat = 5; adp_pat = {32{8'hAB}}; adp_pat_en = 1'b1;
    round(1, 0, 0, 0, 32'h0000_1234, 32'h0, rand_line(), 0);
    adp_lat = -1; adp_pat_en = 1'b0;

    round(0, 1, 1, 1, 32'h0, 32'h8000_0040, {32{8'h5A}}, 1);

    stray_req++;
    repeat (4) tick();
    round(1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0, rand_line(), 0);

    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(0, 2);
      round(sel != 1, sel != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, rand_line(), 1'($urandom_range(0, 1)));
    end

    adp_hold = 1'b1;
    fork
      round(0, 1, 0, 0, 32'h0000_0100, 32'h1234_5678, rand_line(), 0);
      begin
        repeat (25) tick();
        adp_hold = 1'b0;
      end
    join
    round(1, 0, 0, 0, 32'h0000_0880, 32'h0, rand_line(), 0);

    // Reset during a D read while the I-cache is also waiting.
    round(1, 0, 0, 0, 32'h0000_0200, 32'h0, rand_line(), 0);
    bus.instr_read = 1'b1; bus.instr_addr = 32'h0000_3333;
    bus.data_read = 1'b1; bus.data_write = 1'b0; bus.data_addr = 32'h0000_5555;
    e.kind = K_DRD; e.addr = line_addr(32'h0000_5555); e.wdata = '0;
    e.follows = 1'b0; e.start_cyc = cyc;
    push(e);
    adp_hold = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    adp_hold = 1'b0;
    last_data = 1'b1;
    e.kind = K_IRD; e.addr = line_addr(32'h0000_3333); e.start_cyc = cyc;
    push(e);
    e.kind = K_DRD; e.addr = line_addr(32'h0000_5555); e.follows = 1'b1;
    push(e);
    serve(1, 1, 0, 0);
    repeat (2) tick();

    for (int r = 0; r < 8; r++) begin
      int sel;
      sel = $urandom_range(0, 2);
      round(sel != 1, sel != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, rand_line(), 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    check("queue_drained", LW'(exp_q.size()), '0);
    check("txn_count", LW'(n_served + n_abandoned), LW'(n_pushed));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
